perf_event_monitor: RTL and testbench

//   Parametrised hardware performance monitor for the pipelined CPU. Counts run cycles and
//   NUM_EVENTS per-cycle event strobes (stall, flush, branch, load-use, ...) while running.

---
 rtl/perf_mon_pkg.sv | 21 ++
 rtl/perf_counter.sv | 36 +++
 rtl/perf_event_monitor.sv | 115 +++++++++++
 tb/tb_perf_event_monitor.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/perf_mon_pkg.sv
// Shared definitions for the performance monitor: FSM encoding, counter indices, select width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package perf_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2,
        ST_DONE   = 2'd3
    } mon_state_t;

    // Counter slot 0 is always the run-cycle counter; events follow at 1..NUM_EVENTS.
    localparam int CYCLE_IDX = 0;

    // Width of the shadow read index covering the cycle counter plus every event counter.
    function automatic int sel_w(input int num_events);
        return (num_events < 1) ? 1 : $clog2(num_events + 1);
    endfunction

endpackage

// File: rtl/perf_counter.sv
// One performance counter with selectable saturate/wrap and a sticky overflow flag.
// Latency: an increment is visible on cnt_o the cycle after inc_i is sampled.
// Backpressure: none; inc_i is sampled every cycle, clr_i dominates inc_i.
module perf_counter
    import perf_mon_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int SATURATE = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    // Increment, and on an increment from all-ones either hold or wrap while latching overflow.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_o <= '0;
            ovf_o <= 1'b0;
        end else if (clr_i) begin
            cnt_o <= '0;
            ovf_o <= 1'b0;
        end else if (inc_i) begin
            if (&cnt_o) begin
                ovf_o <= 1'b1;
                cnt_o <= (SATURATE != 0) ? cnt_o : '0;
            end else begin
                cnt_o <= cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: rtl/perf_event_monitor.sv
// Run-cycle and event counters with a snapshot shadow bank, cycle limit and registered readout.
// Latency: counters update on the counting edge; rd_data_o is shadow[rd_sel_i] one cycle later.
// Backpressure: none; all inputs are sampled every cycle, priority reset > clear > snap > count.
module perf_event_monitor
    import perf_mon_pkg::*;
#(
    parameter int NUM_EVENTS  = 4,
    parameter int CNT_W       = 32,
    parameter int SATURATE    = 1,
    parameter int CYCLE_LIMIT = 30,
    parameter int SEL_W       = sel_w(NUM_EVENTS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  clear_i,
    input  logic                  freeze_i,
    input  logic                  snap_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic [SEL_W-1:0]      rd_sel_i,
    output logic [CNT_W-1:0]      rd_data_o,
    output logic [NUM_EVENTS:0]   ovf_o,
    output logic                  done_o,
    output logic                  running_o
);

    localparam int               NUM_CNT  = NUM_EVENTS + 1;
    localparam logic [SEL_W-1:0] MAX_SEL  = SEL_W'(NUM_EVENTS);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(CYCLE_LIMIT - 1);

    mon_state_t         state;
    mon_state_t         state_nxt;
    logic               count_en;
    logic               limit_hit;
    logic [NUM_CNT-1:0] inc;
    logic [CNT_W-1:0]   live   [NUM_CNT];
    logic [CNT_W-1:0]   shadow [NUM_CNT];

    // Count only in RUN with freeze low; clear suppresses the increment on its own edge.
    assign count_en  = (state == ST_RUN) && !freeze_i && !clear_i;
    // The limit is reached on the edge whose increment makes the cycle count equal CYCLE_LIMIT.
    assign limit_hit = (CYCLE_LIMIT != 0) && count_en && (live[CYCLE_IDX] == LIMIT_M1);
    assign inc       = {event_i & {NUM_EVENTS{count_en}}, count_en};

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        perf_counter #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (clear_i),
            .inc_i (inc[g]),
            .cnt_o (live[g]),
            .ovf_o (ovf_o[g])
        );
    end

    // Next state: clear wins, reaching the limit beats stop/freeze, DONE only leaves via clear.
    always_comb begin
        state_nxt = state;
        if (clear_i) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (start_i) state_nxt = ST_RUN;
                ST_RUN: begin
                    if (limit_hit)     state_nxt = ST_DONE;
                    else if (!start_i) state_nxt = ST_IDLE;
                    else if (freeze_i) state_nxt = ST_FROZEN;
                end
                ST_FROZEN: begin
                    if (!start_i)      state_nxt = ST_IDLE;
                    else if (!freeze_i) state_nxt = ST_RUN;
                end
                ST_DONE:   state_nxt = ST_DONE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register with status outputs registered from the next state so they track it exactly.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= ST_IDLE;
            running_o <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            state     <= state_nxt;
            running_o <= (state_nxt == ST_RUN);
            done_o    <= (state_nxt == ST_DONE);
        end
    end

    // Shadow bank captures the pre-increment live values; clear zeroes it even alongside snap.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NUM_CNT; i++) shadow[i] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < NUM_CNT; i++) shadow[i] <= '0;
        end else if (snap_i) begin
            for (int i = 0; i < NUM_CNT; i++) shadow[i] <= live[i];
        end
    end

    // Registered readout; indices past the last event counter read as zero.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_data_o <= '0;
        end else begin
            rd_data_o <= (rd_sel_i <= MAX_SEL) ? shadow[rd_sel_i] : '0;
        end
    end

endmodule

// File: tb/tb_perf_event_monitor.sv
// Directed bench: default-width monitor plus two 4-bit variants (saturate and wrap) sharing stimulus.
// Latency: checks sample #1 after the rising edge; readout checked one edge after rd_sel changes.
// Backpressure: n/a.
module tb_perf_event_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, clear = 1'b0, freeze = 1'b0, snap = 1'b0;
    logic [3:0] ev = 4'b0;
    logic [2:0] rd_sel = 3'd0;

    logic [31:0] rd_main;
    logic [3:0]  rd_sat, rd_wrap;
    logic [4:0]  ovf_main, ovf_sat, ovf_wrap;
    logic        done_main, done_sat, done_wrap;
    logic        run_main, run_sat, run_wrap;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    perf_event_monitor #(.NUM_EVENTS(4), .CNT_W(32), .SATURATE(1), .CYCLE_LIMIT(30)) u_main (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .clear_i(clear), .freeze_i(freeze),
        .snap_i(snap), .event_i(ev), .rd_sel_i(rd_sel), .rd_data_o(rd_main),
        .ovf_o(ovf_main), .done_o(done_main), .running_o(run_main));

    perf_event_monitor #(.NUM_EVENTS(4), .CNT_W(4), .SATURATE(1), .CYCLE_LIMIT(0)) u_sat (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .clear_i(clear), .freeze_i(freeze),
        .snap_i(snap), .event_i(ev), .rd_sel_i(rd_sel), .rd_data_o(rd_sat),
        .ovf_o(ovf_sat), .done_o(done_sat), .running_o(run_sat));

    perf_event_monitor #(.NUM_EVENTS(4), .CNT_W(4), .SATURATE(0), .CYCLE_LIMIT(0)) u_wrap (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .clear_i(clear), .freeze_i(freeze),
        .snap_i(snap), .event_i(ev), .rd_sel_i(rd_sel), .rd_data_o(rd_wrap),
        .ovf_o(ovf_wrap), .done_o(done_wrap), .running_o(run_wrap));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_sel(input logic [2:0] sel);
        rd_sel = sel;
        tick();
    endtask

    task automatic do_clear();
        start = 1'b0; freeze = 1'b0; snap = 1'b0; ev = 4'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (rd_main !== 32'd0) begin errors++; $display("FAIL reset_rd: got %0d want 0", rd_main); end
        checks++; if (ovf_main !== 5'd0) begin errors++; $display("FAIL reset_ovf: got %b want 00000", ovf_main); end
        checks++; if (done_main !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_main); end
        checks++; if (run_main !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", run_main); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // 10 counting edges with event 0; snap on the 11th edge sees the pre-increment 10/10.
    task automatic test_basic();
        do_clear();
        start = 1'b1;
        tick();
        checks++; if (run_main !== 1'b1) begin errors++; $display("FAIL basic_running: got %b want 1", run_main); end
        ev = 4'b0001;
        repeat (10) tick();
        snap = 1'b1;
        tick();
        snap = 1'b0; start = 1'b0; ev = 4'b0;
        read_sel(3'd0);
        checks++; if (rd_main !== 32'd10) begin errors++; $display("FAIL basic_cycles: got %0d want 10", rd_main); end
        read_sel(3'd1);
        checks++; if (rd_main !== 32'd10) begin errors++; $display("FAIL basic_ev1: got %0d want 10", rd_main); end
        checks++; if (ovf_main !== 5'd0) begin errors++; $display("FAIL basic_ovf: got %b want 00000", ovf_main); end
        checks++; if (run_main !== 1'b0) begin errors++; $display("FAIL basic_stop: got %b want 0", run_main); end
    endtask

    // 3 counting edges, 5 frozen edges, 1 resume edge (FROZEN->RUN, no count), 4 counting edges.
    task automatic test_freeze();
        do_clear();
        start = 1'b1;
        tick();
        ev = 4'b0010;
        repeat (3) tick();
        freeze = 1'b1;
        repeat (5) tick();
        checks++; if (run_main !== 1'b0) begin errors++; $display("FAIL freeze_running: got %b want 0", run_main); end
        freeze = 1'b0;
        tick();
        repeat (4) tick();
        snap = 1'b1;
        tick();
        snap = 1'b0; start = 1'b0; ev = 4'b0;
        read_sel(3'd0);
        checks++; if (rd_main !== 32'd7) begin errors++; $display("FAIL freeze_cycles: got %0d want 7", rd_main); end
        read_sel(3'd2);
        checks++; if (rd_main !== 32'd7) begin errors++; $display("FAIL freeze_ev2: got %0d want 7", rd_main); end
        read_sel(3'd1);
        checks++; if (rd_main !== 32'd0) begin errors++; $display("FAIL freeze_ev1: got %0d want 0", rd_main); end
    endtask

    // 20 increments into 4-bit counters: saturate holds at 15, wrap ends at 4; both flag overflow.
    task automatic test_overflow();
        do_clear();
        start = 1'b1;
        tick();
        ev = 4'b0001;
        repeat (20) tick();
        snap = 1'b1;
        tick();
        snap = 1'b0; start = 1'b0; ev = 4'b0;
        read_sel(3'd1);
        checks++; if (rd_sat !== 4'd15) begin errors++; $display("FAIL ovf_sat_ev1: got %0d want 15", rd_sat); end
        checks++; if (rd_wrap !== 4'd4) begin errors++; $display("FAIL ovf_wrap_ev1: got %0d want 4", rd_wrap); end
        checks++; if (rd_main !== 32'd20) begin errors++; $display("FAIL ovf_main_ev1: got %0d want 20", rd_main); end
        checks++; if (ovf_sat !== 5'b00011) begin errors++; $display("FAIL ovf_sat_flags: got %b want 00011", ovf_sat); end
        checks++; if (ovf_wrap !== 5'b00011) begin errors++; $display("FAIL ovf_wrap_flags: got %b want 00011", ovf_wrap); end
        checks++; if (ovf_main !== 5'b00000) begin errors++; $display("FAIL ovf_main_flags: got %b want 00000", ovf_main); end
        read_sel(3'd0);
        checks++; if (rd_wrap !== 4'd4) begin errors++; $display("FAIL ovf_wrap_cycles: got %0d want 4", rd_wrap); end
    endtask

    // done rises on the 30th counting edge; later events ignored; clear returns to zero and IDLE.
    task automatic test_limit();
        do_clear();
        start = 1'b1;
        tick();
        ev = 4'b0001;
        repeat (29) tick();
        checks++; if (done_main !== 1'b0) begin errors++; $display("FAIL limit_early: got %b want 0", done_main); end
        tick();
        checks++; if (done_main !== 1'b1) begin errors++; $display("FAIL limit_done: got %b want 1", done_main); end
        checks++; if (run_main !== 1'b0) begin errors++; $display("FAIL limit_running: got %b want 0", run_main); end
        repeat (5) tick();
        snap = 1'b1;
        tick();
        snap = 1'b0;
        read_sel(3'd0);
        checks++; if (rd_main !== 32'd30) begin errors++; $display("FAIL limit_cycles: got %0d want 30", rd_main); end
        read_sel(3'd1);
        checks++; if (rd_main !== 32'd30) begin errors++; $display("FAIL limit_ev1: got %0d want 30", rd_main); end
        do_clear();
        checks++; if (done_main !== 1'b0) begin errors++; $display("FAIL limit_clear_done: got %b want 0", done_main); end
        read_sel(3'd0);
        checks++; if (rd_main !== 32'd0) begin errors++; $display("FAIL limit_clear_cycles: got %0d want 0", rd_main); end
    endtask

    // Snap coincident with an event takes 6 while live goes to 7; clear+snap zeroes the shadow.
    task automatic test_snap();
        do_clear();
        start = 1'b1;
        tick();
        ev = 4'b0001;
        repeat (6) tick();
        snap = 1'b1;
        tick();
        snap = 1'b0; ev = 4'b0; freeze = 1'b1;
        read_sel(3'd1);
        checks++; if (rd_main !== 32'd6) begin errors++; $display("FAIL snap_shadow: got %0d want 6", rd_main); end
        snap = 1'b1;
        tick();
        snap = 1'b0;
        read_sel(3'd1);
        checks++; if (rd_main !== 32'd7) begin errors++; $display("FAIL snap_live: got %0d want 7", rd_main); end
        start = 1'b0; freeze = 1'b0;
        clear = 1'b1; snap = 1'b1;
        tick();
        clear = 1'b0; snap = 1'b0;
        read_sel(3'd1);
        checks++; if (rd_main !== 32'd0) begin errors++; $display("FAIL snap_clear: got %0d want 0", rd_main); end
    endtask

    // Asynchronous reset between edges zeroes outputs at once; out-of-range select reads zero.
    task automatic test_reset_midrun();
        do_clear();
        start = 1'b1;
        tick();
        ev = 4'b1111;
        repeat (5) tick();
        snap = 1'b1;
        tick();
        snap = 1'b0;
        read_sel(3'd1);
        checks++; if (rd_main !== 32'd5) begin errors++; $display("FAIL mid_pre_rd: got %0d want 5", rd_main); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (rd_main !== 32'd0) begin errors++; $display("FAIL mid_rst_rd: got %0d want 0", rd_main); end
        checks++; if (run_main !== 1'b0) begin errors++; $display("FAIL mid_rst_running: got %b want 0", run_main); end
        checks++; if (rd_sat !== 4'd0) begin errors++; $display("FAIL mid_rst_rd_sat: got %0d want 0", rd_sat); end
        start = 1'b0; ev = 4'b0;
        #2;
        rst_n = 1'b1;
        read_sel(3'd2);
        checks++; if (rd_main !== 32'd0) begin errors++; $display("FAIL mid_rst_shadow: got %0d want 0", rd_main); end
        start = 1'b1;
        tick();
        repeat (3) tick();
        snap = 1'b1;
        tick();
        snap = 1'b0; start = 1'b0;
        read_sel(3'd0);
        checks++; if (rd_main !== 32'd3) begin errors++; $display("FAIL mid_restart_cycles: got %0d want 3", rd_main); end
        read_sel(3'd7);
        checks++; if (rd_main !== 32'd0) begin errors++; $display("FAIL sel7_main: got %0d want 0", rd_main); end
        checks++; if (rd_sat !== 4'd0) begin errors++; $display("FAIL sel7_sat: got %0d want 0", rd_sat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_freeze();
        test_overflow();
        test_limit();
        test_snap();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
